// File: rtl/data_inf_burst_arbiter.sv
// Round-robin burst arbiter: shares one valid/ready stream among NUM requesters,
// granting one burst (ended by last or MAX_BURST beats) at a time.
module data_inf_burst_arbiter #(
    parameter int NUM       = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [NUM-1:0]                s_valid,
    input  logic [NUM*DSIZE-1:0]          s_data,
    input  logic [NUM-1:0]                s_last,
    output logic [NUM-1:0]                s_ready,
    output logic                          m_valid,
    output logic [DSIZE-1:0]              m_data,
    output logic                          m_last,
    input  logic                          m_ready,
    output logic [$clog2(NUM)-1:0]        m_sel,
    output logic                          busy
);

    localparam int SelW = $clog2(NUM);
    localparam int CntW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e            state_q, state_d;
    logic [SelW-1:0]   grant_q, grant_d;
    logic [SelW-1:0]   last_grant_q, last_grant_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [SelW-1:0]   pick;

    // First valid requester at or after last_grant+1, wrapping at NUM.
    always_comb begin
        logic found;
        found = 1'b0;
        pick  = grant_q;
        for (int k = 1; k <= NUM; k++) begin
            int cand;
            cand = (int'(last_grant_q) + k) % NUM;
            if (!found && s_valid[SelW'(cand)]) begin
                found = 1'b1;
                pick  = SelW'(cand);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        m_valid      = 1'b0;
        m_data       = '0;
        m_last       = 1'b0;
        s_ready      = '0;
        case (state_q)
            StIdle: begin
                if (|s_valid) begin
                    grant_d = pick;
                    count_d = '0;
                    state_d = StExec;
                end
            end
            StExec: begin
                m_valid          = s_valid[grant_q];
                m_data           = s_data[int'(grant_q)*DSIZE +: DSIZE];
                s_ready[grant_q] = m_ready;
                m_last           = m_valid &&
                                   (s_last[grant_q] || (count_q == CntW'(MAX_BURST - 1)));
                if (m_valid && m_ready) begin
                    count_d = count_q + CntW'(1);
                    if (m_last) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= SelW'(NUM - 1);
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
        end
    end

    assign m_sel = grant_q;
    assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_data_inf_burst_arbiter.sv
// Self-checking bench for data_inf_burst_arbiter: vector table, corner sequences
// and a randomized run against a queue-based round-robin reference.
module tb_data_inf_burst_arbiter;

    localparam int NUM  = 4;
    localparam int DW   = 8;
    localparam int MAXB = 16;

    logic              clock;
    logic              rst;
    logic [NUM-1:0]    s_valid;
    logic [NUM*DW-1:0] s_data;
    logic [NUM-1:0]    s_last;
    logic [NUM-1:0]    s_ready;
    logic              m_valid;
    logic [DW-1:0]     m_data;
    logic              m_last;
    logic              m_ready;
    logic [1:0]        m_sel;
    logic              busy;

    data_inf_burst_arbiter #(.NUM(NUM), .DSIZE(DW), .MAX_BURST(MAXB)) dut (
        .clock   (clock),
        .rst     (rst),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_ready (m_ready),
        .m_sel   (m_sel),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Samples once per cycle until a handshake is seen; leaves time at the sample point.
    task automatic wait_xfer(input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            #3;
            if (m_valid && m_ready) begin
                got = 1'b1;
                return;
            end
            @(posedge clock);
            #1;
        end
    endtask

    typedef struct {
        logic [3:0] sv;
        logic [3:0] sl;
        logic       mr;
        logic       mv;
        logic [3:0] sr;
        logic       ml;
        int         sel;
        logic       bz;
        logic [7:0] dat;
    } vec_t;

    vec_t tbl [15];

    // Random-phase reference: per-source beat streams consumed in grant order.
    logic [7:0] dat [NUM][64];
    logic       lst [NUM][64];
    int         head [NUM];
    int         len  [NUM];

    function automatic int rr_next(input int lastg);
        for (int k = 1; k <= NUM; k++) begin
            int c;
            c = (lastg + k) % NUM;
            if (head[c] < len[c]) return c;
        end
        return -1;
    endfunction

    initial begin
        int  sel_log [5];
        int  t_log   [5];
        int  n;
        int  b;
        bit  got;
        int  exp_g;
        int  beats;
        bit  exp_l;
        bit  drained;

        tbl[0]  = '{4'b0001, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 8'h00};
        tbl[1]  = '{4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0, 0, 1'b1, 8'h11};
        tbl[2]  = '{4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0001, 1'b0, 0, 1'b1, 8'h11};
        tbl[3]  = '{4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b1, 0, 1'b1, 8'h11};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b1, 8'h00};
        tbl[5]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 8'h00};
        tbl[6]  = '{4'b0100, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 0, 1'b0, 8'h00};
        tbl[7]  = '{4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 2, 1'b1, 8'h33};
        tbl[8]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2, 1'b1, 8'h00};
        tbl[9]  = '{4'b1000, 4'b1000, 1'b0, 1'b0, 4'b0000, 1'b0, 2, 1'b0, 8'h00};
        tbl[10] = '{4'b1000, 4'b1000, 1'b0, 1'b1, 4'b0000, 1'b1, 3, 1'b1, 8'h44};
        tbl[11] = '{4'b0000, 4'b1000, 1'b1, 1'b0, 4'b1000, 1'b0, 3, 1'b1, 8'h00};
        tbl[12] = '{4'b1000, 4'b1000, 1'b1, 1'b1, 4'b1000, 1'b1, 3, 1'b1, 8'h44};
        tbl[13] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 3, 1'b1, 8'h00};
        tbl[14] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 3, 1'b0, 8'h00};

        rst     = 1'b1;
        s_valid = '0;
        s_last  = '0;
        s_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        m_ready = 1'b0;
        #3;
        chk("reset m_valid", int'(m_valid), 0);
        chk("reset s_ready", int'(s_ready), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset m_sel", int'(m_sel), 0);
        chk("reset m_last", int'(m_last), 0);
        tick();
        rst = 1'b0;

        // Cycle-by-cycle vectors: 3-beat burst from 0, single beats from 2 and 3.
        for (int k = 0; k < 15; k++) begin
            s_valid = tbl[k].sv;
            s_last  = tbl[k].sl;
            m_ready = tbl[k].mr;
            #3;
            chk($sformatf("vec%0d m_valid", k), int'(m_valid), int'(tbl[k].mv));
            chk($sformatf("vec%0d s_ready", k), int'(s_ready), int'(tbl[k].sr));
            chk($sformatf("vec%0d m_last", k), int'(m_last), int'(tbl[k].ml));
            chk($sformatf("vec%0d m_sel", k), int'(m_sel), tbl[k].sel);
            chk($sformatf("vec%0d busy", k), int'(busy), int'(tbl[k].bz));
            if (tbl[k].mv) chk($sformatf("vec%0d m_data", k), int'(m_data), int'(tbl[k].dat));
            tick();
        end

        // All four valid with one-beat bursts: order 0,1,2,3,0, three cycles apart.
        s_valid = 4'b1111;
        s_last  = 4'b1111;
        m_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 5; c++) begin
            #3;
            if (m_valid && m_ready) begin
                sel_log[n] = int'(m_sel);
                t_log[n]   = c;
                n++;
            end
            tick();
        end
        s_valid = '0;
        chk("rr transfer count", n, 5);
        if (n == 5) begin
            chk("rr first latency", t_log[0], 1);
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("rr order %0d", k), sel_log[k], k % NUM);
                if (k > 0) chk($sformatf("rr gap %0d", k), t_log[k] - t_log[k-1], 3);
            end
        end
        tick();

        // Requester 2: 20 beats, forced last at beat 16, real last at beat 20.
        s_valid = 4'b0100;
        b = 0;
        for (int c = 0; c < 100 && b < 20; c++) begin
            s_last         = (b == 19) ? 4'b0100 : 4'b0000;
            s_data[2*DW +: DW] = DW'(b);
            #3;
            if (m_valid && m_ready) begin
                chk($sformatf("max beat%0d m_sel", b + 1), int'(m_sel), 2);
                chk($sformatf("max beat%0d m_last", b + 1), int'(m_last),
                    (b == MAXB - 1 || b == 19) ? 1 : 0);
                chk($sformatf("max beat%0d m_data", b + 1), int'(m_data), b);
                b++;
            end
            tick();
        end
        chk("max beats transferred", b, 20);
        s_valid = '0;
        s_last  = '0;
        tick();

        // Reset during beat 2 of a burst from requester 1.
        s_valid = 4'b0010;
        s_data[1*DW +: DW] = 8'h5A;
        wait_xfer(10, got);
        chk("rstmid first beat seen", int'(got), 1);
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk("rstmid m_valid", int'(m_valid), 0);
        chk("rstmid s_ready", int'(s_ready), 0);
        chk("rstmid busy", int'(busy), 0);
        chk("rstmid m_sel", int'(m_sel), 0);
        chk("rstmid m_last", int'(m_last), 0);
        tick();
        rst     = 1'b0;
        s_valid = 4'b0011;
        s_last  = 4'b0011;
        wait_xfer(10, got);
        chk("post-rst grant seen", int'(got), 1);
        chk("post-rst grant", int'(m_sel), 0);
        tick();

        // Granted requester 3 stalls for 10 cycles while requester 0 waits.
        s_valid = 4'b1001;
        s_last  = 4'b0000;
        wait_xfer(10, got);
        chk("stall grant seen", int'(got), 1);
        chk("stall grant", int'(m_sel), 3);
        chk("stall first m_last", int'(m_last), 0);
        tick();
        s_valid = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            #3;
            chk($sformatf("stall%0d m_valid", c), int'(m_valid), 0);
            chk($sformatf("stall%0d s_ready0", c), int'(s_ready[0]), 0);
            chk($sformatf("stall%0d m_sel", c), int'(m_sel), 3);
            tick();
        end
        s_valid = 4'b1001;
        s_last  = 4'b1000;
        #3;
        chk("stall resume m_valid", int'(m_valid), 1);
        chk("stall resume m_last", int'(m_last), 1);
        chk("stall resume m_sel", int'(m_sel), 3);
        tick();
        s_valid = '0;
        s_last  = '0;

        // Randomized run: sources stream queued bursts; reference predicts grant, data, last.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            head[i] = 0;
            len[i]  = 0;
            for (int bu = 0; bu < 3; bu++) begin
                int bl;
                bl = int'($urandom_range(1, 20));
                for (int j = 0; j < bl; j++) begin
                    dat[i][len[i]] = DW'($urandom);
                    lst[i][len[i]] = (j == bl - 1);
                    len[i]++;
                end
            end
        end
        exp_g   = rr_next(NUM - 1);
        beats   = 0;
        drained = 1'b0;
        for (int c = 0; c < 4000 && !drained; c++) begin
            for (int i = 0; i < NUM; i++) begin
                s_valid[i] = (head[i] < len[i]);
                s_last[i]  = (head[i] < len[i]) ? lst[i][head[i]] : 1'b0;
                s_data[i*DW +: DW] = (head[i] < len[i]) ? dat[i][head[i]] : '0;
            end
            m_ready = ($urandom_range(0, 3) != 0);
            #3;
            chk("rand s_ready other", int'(s_ready & ~(4'b0001 << m_sel)), 0);
            if (m_valid && m_ready) begin
                chk("rand m_sel", int'(m_sel), exp_g);
                if (exp_g >= 0) begin
                    exp_l = lst[exp_g][head[exp_g]] || (beats == MAXB - 1);
                    chk("rand m_data", int'(m_data), int'(dat[exp_g][head[exp_g]]));
                    chk("rand m_last", int'(m_last), int'(exp_l));
                    head[exp_g]++;
                    beats++;
                    if (exp_l) begin
                        beats = 0;
                        exp_g = rr_next(exp_g);
                    end
                end
            end
            drained = 1'b1;
            for (int i = 0; i < NUM; i++) if (head[i] < len[i]) drained = 1'b0;
            tick();
        end
        chk("rand all beats drained", int'(drained), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_inf_burst_arbiter.md
Name: data_inf_burst_arbiter

Overview:
- Shares one downstream valid/ready data stream among NUM upstream requesters.
- Grants are round-robin, one burst at a time. A burst ends on the source's last flag or after MAX_BURST beats, whichever comes first.
- Sits in front of a single-consumer data_inf_c datapath. Sequences access with an IDLE/EXEC/DONE state machine.

Parameters:
- NUM, 4, number of requesters (2..16).
- DSIZE, 8, data width per beat.
- MAX_BURST, 16, maximum beats per grant (>=1).

Ports:
- clock  input  1  single clock.
- rst  input  1  reset, asynchronous, active-high.
- s_valid  input  NUM  per-requester valid.
- s_data  input  NUM*DSIZE  per-requester data; requester i occupies bits [i*DSIZE +: DSIZE].
- s_last  input  NUM  per-requester end-of-burst flag.
- s_ready  output  NUM  per-requester ready.
- m_valid  output  1  downstream valid.
- m_data  output  DSIZE  downstream data.
- m_last  output  1  downstream end-of-burst.
- m_ready  input  1  downstream ready.
- m_sel  output  $clog2(NUM)  index of the current grant.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, grant=0, last_grant=NUM-1, beat count=0.
  - m_valid=0, s_ready=0, m_last=0, m_sel=0, busy=0.
  - Reset asserted mid-burst aborts the burst immediately; no handshake completes in the reset cycle.
- IDLE:
  - If any s_valid is high, select the first requester with valid high, searching from last_grant+1 modulo NUM.
  - Register the choice into grant, clear the beat count, go to EXEC.
  - No data passes in IDLE: m_valid=0, s_ready=0.
- EXEC:
  - Combinational pass-through of the granted requester g: m_valid=s_valid[g], m_data=s_data[g], s_ready[g]=m_ready. All other s_ready bits are 0.
  - m_last = s_last[g] OR (count==MAX_BURST-1), qualified by m_valid.
  - A beat transfers when m_valid & m_ready; the count increments on each transfer.
  - A transfer with m_last=1 moves the FSM to DONE.
  - If s_valid[g] drops, the grant is held indefinitely; there is no timeout.
- DONE:
  - One cycle; last_grant<=grant; next state IDLE.
  - m_valid=0, all s_ready=0.
- Latency:
  - A valid arriving in IDLE at cycle 0 can transfer its first beat at cycle 1 at the earliest.
  - The minimum gap between consecutive bursts is 2 cycles (DONE, then IDLE).
- Forced termination:
  - At MAX_BURST beats the burst ends even if s_last[g]=0. The remaining data of that source is served on a later grant, with round-robin continuing past it.
  - MAX_BURST=1: every beat carries m_last=1.
- Priority and stability:
  - A single active requester is re-granted after every DONE.
  - Requests arriving during EXEC or DONE are ignored until the next IDLE.
  - m_sel=grant, stable from EXEC entry until the next IDLE selection.
- Width rules:
  - Beat count is $clog2(MAX_BURST+1) bits and never wraps.
  - last_grant+1 wraps from NUM-1 to 0.

Test Plan:
- Reset, then s_valid=4'b0001, 3-beat burst from requester 0 with s_last on beat 3, m_ready=1 -> m_sel=0; beats transfer on cycles 1–3; m_last only on beat 3; DONE on cycle 4; busy low on cycle 5.
- All four requesters valid continuously, each burst 1 beat long -> grant order 0,1,2,3,0 with exactly 2 idle cycles between bursts.
- Requester 2 sends 20 beats with no s_last, MAX_BURST=16, others idle -> m_last forced on beat 16; re-grant to 2; beats 17–20 follow; m_last on beat 20 only because s_last is set on it.
- m_ready toggling 1,0,1,0 during a 4-beat burst -> m_data stable while m_ready=0; count advances only on transfers; s_ready[g] tracks m_ready; other s_ready bits stay 0.
- rst pulsed high during beat 2 of a 5-beat burst from requester 1 -> outputs go to reset values immediately; after release, requester 0 wins first if valid (last_grant=NUM-1).
- Granted requester 3 drops s_valid for 10 cycles while requester 0 is valid -> grant held at 3, m_valid=0, s_ready[0]=0 throughout; burst resumes when s_valid[3] returns.
